// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg -- shared definitions for the data-memory responder.
//   * default geometry of the core port (data width, array depth, index width)
//   * write-buffer entry layout {index, data} for the default geometry
//   * drain FSM state encoding (IDLE=0, BUSY=1)
//   * helper to size the drain latency counter
// -----------------------------------------------------------------------------
package dm_pkg;

   localparam int DM_DATA_W    = 32;
   localparam int DM_MEM_DEPTH = 1024;
   localparam int DM_IDX_W     = $clog2(DM_MEM_DEPTH);

   // Entry layout for the default geometry; the buffer declares the same
   // layout locally so that non-default parameter sets stay consistent.
   typedef struct packed {
      logic [DM_IDX_W-1:0]  index;
      logic [DM_DATA_W-1:0] data;
   } dm_wb_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } dm_state_e;

   // Counter holds values 0..lat-1; keep at least one bit for lat == 1.
   function automatic int dm_cnt_w(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/dm_write_buffer.sv
// -----------------------------------------------------------------------------
// dm_write_buffer -- posted-store FIFO with youngest-match forwarding lookup.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_push/i_idx/i_data store request (accepted when not full, or when a pop
//                       happens on the same edge)
//   i_pop               remove head entry (ignored when empty)
//   o_head_idx/data     oldest entry
//   o_full/o_empty      occupancy flags
//   i_lk_idx            forwarding lookup index
//   o_lk_hit/o_lk_data  youngest valid entry matching i_lk_idx
// -----------------------------------------------------------------------------
module dm_write_buffer
   import dm_pkg::*;
#(
   parameter int IDX_W = DM_IDX_W,
   parameter int DW    = DM_DATA_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [DW-1:0]    i_data,
   input  logic             i_pop,
   output logic [IDX_W-1:0] o_head_idx,
   output logic [DW-1:0]    o_head_data,
   output logic             o_full,
   output logic             o_empty,
   input  logic [IDX_W-1:0] i_lk_idx,
   output logic             o_lk_hit,
   output logic [DW-1:0]    o_lk_data
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [DW-1:0]    data;
   } ent_t;

   ent_t          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_cnt;

   logic w_push_ok, w_pop_ok;

   assign o_full   = (r_cnt == (PW+1)'(DEPTH));
   assign o_empty  = (r_cnt == '0);
   // A pop frees the slot on the same edge, so a full buffer still accepts.
   assign w_push_ok = i_push && (!o_full || i_pop);
   assign w_pop_ok  = i_pop && !o_empty;

   assign o_head_idx  = r_mem[r_rd_ptr].index;
   assign o_head_data = r_mem[r_rd_ptr].data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Entry storage needs no reset: validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= '{index: i_idx, data: i_data};
   end

   // Scan oldest -> youngest so the last match (youngest) wins.
   always_comb begin
      logic [PW-1:0] w_slot;
      o_lk_hit  = 1'b0;
      o_lk_data = '0;
      w_slot    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_slot = r_rd_ptr + PW'(i);
         if (((PW+1)'(i) < r_cnt) && (r_mem[w_slot].index == i_lk_idx)) begin
            o_lk_hit  = 1'b1;
            o_lk_data = r_mem[w_slot].data;
         end
      end
   end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder -- memory side of the core's data-memory port. Stores are
// posted into a write buffer and drained into the word array with a fixed
// latency; loads are answered combinationally with store-to-load forwarding.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   DM_Address      word address (upper bits above the array index alias)
//   DM_enable       store request, sampled on rising clk
//   DM_Write_Data   store data
//   DM_Read_Data    load data (combinational)
//   wb_full/empty   write-buffer occupancy
//   overflow        sticky: a store was dropped because the buffer was full
// Build option:
//   DM_CLEAR_ON_RST_EN  when defined, rst also clears every array word to 0.
// -----------------------------------------------------------------------------
module dm_responder
   import dm_pkg::*;
#(
   parameter int data_size = 32,
   parameter int mem_size  = 16,
   parameter int mem_depth = 1024,
   parameter int WB_DEPTH  = 4,
   parameter int WR_LAT    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [mem_size-1:0]  DM_Address,
   input  logic                 DM_enable,
   input  logic [data_size-1:0] DM_Write_Data,
   output logic [data_size-1:0] DM_Read_Data,
   output logic                 wb_full,
   output logic                 wb_empty,
   output logic                 overflow
);

   localparam int IW = $clog2(mem_depth);
   localparam int CW = dm_cnt_w(WR_LAT);

   dm_state_e            r_state;
   logic [CW-1:0]        r_cnt;
   logic                 r_ovf;
   logic [data_size-1:0] r_mem [mem_depth];

   logic [IW-1:0]        w_idx;
   logic                 w_pop;
   logic [IW-1:0]        w_head_idx;
   logic [data_size-1:0] w_head_data;
   logic                 w_hit;
   logic [data_size-1:0] w_fwd;
   logic                 w_unused;

   assign w_idx    = DM_Address[IW-1:0];
   assign w_unused = ^DM_Address[mem_size-1:IW];

   // The head commits on the edge where the latency counter has run out.
   assign w_pop = (r_state == ST_BUSY) && (r_cnt == '0);

   dm_write_buffer #(
      .IDX_W (IW),
      .DW    (data_size),
      .DEPTH (WB_DEPTH)
   ) u_wb (
      .clk         (clk),
      .rst         (rst),
      .i_push      (DM_enable),
      .i_idx       (w_idx),
      .i_data      (DM_Write_Data),
      .i_pop       (w_pop),
      .o_head_idx  (w_head_idx),
      .o_head_data (w_head_data),
      .o_full      (wb_full),
      .o_empty     (wb_empty),
      .i_lk_idx    (w_idx),
      .o_lk_hit    (w_hit),
      .o_lk_data   (w_fwd)
   );

   // Drain FSM. wb_empty is the pre-edge value, so a store pushed on the
   // same edge does not start a drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!wb_empty) begin
                  r_state <= ST_BUSY;
                  r_cnt   <= CW'(WR_LAT - 1);
               end
            end
            ST_BUSY: begin
               if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
               else             r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         if (DM_enable && wb_full && !w_pop) r_ovf <= 1'b1;
      end
   end

   assign overflow = r_ovf;

`ifdef DM_CLEAR_ON_RST_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < mem_depth; k++) r_mem[k] <= '0;
      end else if (w_pop) begin
         r_mem[w_head_idx] <= w_head_data;
      end
   end
`else
   // Reset holds the FSM in IDLE, so no commit can happen while rst is high.
   always_ff @(posedge clk) begin
      if (w_pop) r_mem[w_head_idx] <= w_head_data;
   end
`endif

   // A buffered entry always holds the newest value for its index.
   assign DM_Read_Data = w_hit ? w_fwd : r_mem[w_idx];

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] DM_Address = '0;
   logic        DM_enable = 1'b0;
   logic [31:0] DM_Write_Data = '0;
   logic [31:0] DM_Read_Data;
   logic        wb_full, wb_empty, overflow;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_rst;

   dm_responder #(
      .data_size (32), .mem_size (16), .mem_depth (1024),
      .WB_DEPTH  (4),  .WR_LAT   (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .DM_Address    (DM_Address),
      .DM_enable     (DM_enable),
      .DM_Write_Data (DM_Write_Data),
      .DM_Read_Data  (DM_Read_Data),
      .wb_full       (wb_full),
      .wb_empty      (wb_empty),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [15:0] a, input logic [31:0] d);
      DM_Address    = a;
      DM_Write_Data = d;
      DM_enable     = 1'b1;
   endtask

   // Load through the scoreboard: expectation queued with the stimulus,
   // popped once the combinational output has settled.
   task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
      DM_Address = a;
      exp_q.push_back(exp);
      #1;
      chk(tag, DM_Read_Data, exp_q.pop_front());
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_empty", {31'b0, wb_empty}, 32'd1);
      chk("rst_full",  {31'b0, wb_full},  32'd0);
      chk("rst_ovf",   {31'b0, overflow}, 32'd0);
`ifdef DM_CLEAR_ON_RST_EN
      rd("rst_ld7", 16'd7, 32'd0);
`endif

      // single store: forwarded from edge 1, committed at edge 4
      store(16'd5, 32'h12345678);
      tick();                                   // e1
      DM_enable = 1'b0;
      rd("fwd5_e1", 16'd5, 32'h12345678);
      chk("e1_empty", {31'b0, wb_empty}, 32'd0);
      tick(); tick();                           // e2, e3
      chk("e3_empty", {31'b0, wb_empty}, 32'd0);
      rd("fwd5_e3", 16'd5, 32'h12345678);
      tick();                                   // e4 commit
      chk("e4_empty", {31'b0, wb_empty}, 32'd1);
      rd("arr5_e4", 16'd5, 32'h12345678);

      // two stores to one address: youngest wins throughout
      store(16'd3, 32'hA);
      tick();
      rd("fwd3_a", 16'd3, 32'hA);
      store(16'd3, 32'hB);
      tick();
      DM_enable = 1'b0;
      for (int j = 0; j < 7; j++) begin
         rd("fwd3_b", 16'd3, 32'hB);
         tick();
      end
      chk("ab_empty", {31'b0, wb_empty}, 32'd1);

      // load and store to same address in one cycle sees the old value
      store(16'd3, 32'hC);
      exp_q.push_back(32'hB);
      #1;
      chk("ld_st_same", DM_Read_Data, exp_q.pop_front());
      tick();
      DM_enable = 1'b0;
      rd("fwd3_c", 16'd3, 32'hC);
      repeat (4) tick();

      // six back-to-back stores; sixth is dropped
      for (int i = 0; i < 6; i++) begin
         if (i < 5) store(16'(20 + i), 32'hD0 + 32'(i));
         else       store(16'd5, 32'hDEAD);
         tick();                                // edge i+1
         if (i == 3) chk("e4_full", {31'b0, wb_full}, 32'd0);
         if (i == 4) chk("e5_full", {31'b0, wb_full}, 32'd1);
         if (i < 5)  chk("ovf_pre", {31'b0, overflow}, 32'd0);
         if (i == 5) begin
            chk("e6_ovf",  {31'b0, overflow}, 32'd1);
            chk("e6_full", {31'b0, wb_full},  32'd1);
         end
      end
      DM_enable = 1'b0;
      for (int j = 7; j <= 16; j++) begin
         tick();
         if (j == 7)  chk("e7_full",   {31'b0, wb_full},  32'd0);
         if (j == 15) chk("e15_empty", {31'b0, wb_empty}, 32'd0);
         if (j == 16) chk("e16_empty", {31'b0, wb_empty}, 32'd1);
      end
      for (int i = 0; i < 5; i++) rd("burst_arr", 16'(20 + i), 32'hD0 + 32'(i));
      rd("dropped5", 16'd5, 32'h12345678);
      chk("ovf_sticky", {31'b0, overflow}, 32'd1);

      // aliasing: upper address bits ignored
      tick();
      store(16'h0405, 32'h5A5A5A5A);
      tick();
      DM_enable = 1'b0;
      rd("alias_fwd", 16'h0005, 32'h5A5A5A5A);
      repeat (4) tick();
      rd("alias_arr", 16'h0005, 32'h5A5A5A5A);
      rd("alias_hi",  16'h0405, 32'h5A5A5A5A);

      // reset mid-drain discards buffered entries
      store(16'd9, 32'h11);
      tick();
      DM_enable = 1'b0;
      repeat (4) tick();
      rd("pre9", 16'd9, 32'h11);
      store(16'd9, 32'h22);
      tick();
      store(16'd10, 32'h33);
      tick();
      DM_enable = 1'b0;
      rd("fwd9_22", 16'd9, 32'h22);
      rst = 1'b1;
      #1;
`ifdef DM_CLEAR_ON_RST_EN
      exp_rst = 32'h0;
`else
      exp_rst = 32'h11;
`endif
      chk("mid_rst_empty", {31'b0, wb_empty}, 32'd1);
      chk("mid_rst_full",  {31'b0, wb_full},  32'd0);
      chk("mid_rst_ovf",   {31'b0, overflow}, 32'd0);
      rd("mid_rst_ld9", 16'd9, exp_rst);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("post_rst_empty", {31'b0, wb_empty}, 32'd1);
      rd("post_rst_ld9", 16'd9, exp_rst);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
